// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the accumulator processor control unit.
// Covers opcodes, FSM states, ALU/PC control codes and branch_ctrl bit positions.
package acc_ctrl_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned PC_SEL_W  = 2;
  localparam int unsigned BR_CTRL_W = 7;
  localparam int unsigned PC_WS_W   = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h4;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h5;
  localparam logic [OPC_W-1:0] OP_AND = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h7;
  localparam logic [OPC_W-1:0] OP_BEQ = 4'h8;
  localparam logic [OPC_W-1:0] OP_BNE = 4'h9;
  localparam logic [OPC_W-1:0] OP_BMI = 4'hA;
  localparam logic [OPC_W-1:0] OP_BPL = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP = 4'hC;
  localparam logic [OPC_W-1:0] OP_JSR = 4'hD;
  localparam logic [OPC_W-1:0] OP_RTS = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEM_RD = 4'd2,
    ST_ALU_WB = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_BRANCH = 4'd5,
    ST_JUMP   = 4'd6,
    ST_RETURN = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_NOT_A  = 3'b100;

  localparam logic [PC_SEL_W-1:0] PC_SEL_INC    = 2'b00;
  localparam logic [PC_SEL_W-1:0] PC_SEL_TARGET = 2'b01;
  localparam logic [PC_SEL_W-1:0] PC_SEL_SAVED  = 2'b10;

  // {restore, jump, inc, PCWrite}
  localparam logic [PC_WS_W-1:0] PCW_INC     = 4'b0011;
  localparam logic [PC_WS_W-1:0] PCW_JUMP    = 4'b0101;
  localparam logic [PC_WS_W-1:0] PCW_RESTORE = 4'b1001;

  localparam int unsigned BR_BEQ  = 6;
  localparam int unsigned BR_BMI  = 5;
  localparam int unsigned BR_BNE  = 4;
  localparam int unsigned BR_BPL  = 3;
  localparam int unsigned BR_Z    = 2;
  localparam int unsigned BR_N    = 1;
  localparam int unsigned BR_COND = 0;

endpackage

// File: rtl/acc_control_unit_flag_reg.sv
// Z/N flag register; captures the accumulator write-back value's zero/sign status.
module acc_flag_reg
  import acc_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_n
);

  logic z_q, z_d;
  logic n_q, n_d;

  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (load) begin
      z_d = (result == DATA_W'(0));
      n_d = result[DATA_W-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign flag_z = z_q;
  assign flag_n = n_q;

endmodule

// File: rtl/acc_control_unit.sv
// Multicycle control FSM for the accumulator processor.
// Outputs decode from state, IR opcode and flags; reset forces every output low.
module acc_control_unit
  import acc_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    instr_in,
  input  logic                 mem_ready,
  input  logic [DATA_W-1:0]    acc_result_in,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_addr_sel,
  output logic                 acc_write,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 alu_src_b,
  output logic [PC_SEL_W-1:0]  pc_mux_sel,
  output logic [BR_CTRL_W-1:0] branch_ctrl,
  output logic [PC_WS_W-1:0]   pc_write_signals,
  output logic                 saved_pc_write,
  output logic                 halted
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opcode;
  logic             flag_z, flag_n;
  logic             unused_operand_bits;

  assign opcode = instr_in[DATA_W-1 -: OPC_W];
  // Operand field is consumed by the datapath, not by control.
  assign unused_operand_bits = ^instr_in[DATA_W-OPC_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    ir_write         = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_addr_sel     = 1'b0;
    acc_write        = 1'b0;
    alu_op           = ALU_PASS_B;
    alu_src_b        = 1'b0;
    pc_mux_sel       = PC_SEL_INC;
    branch_ctrl      = '0;
    pc_write_signals = '0;
    saved_pc_write   = 1'b0;
    halted           = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        pc_mux_sel       = PC_SEL_INC;
        pc_write_signals = PCW_INC;
        case (opcode)
          OP_NOP:                         state_d = ST_FETCH;
          OP_HLT:                         state_d = ST_HALT;
          OP_LDI, OP_NOT:                 state_d = ST_ALU_WB;
          OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = ST_MEM_RD;
          OP_STA:                         state_d = ST_MEM_WR;
          OP_BEQ, OP_BNE, OP_BMI, OP_BPL: state_d = ST_BRANCH;
          OP_JMP, OP_JSR:                 state_d = ST_JUMP;
          OP_RTS:                         state_d = ST_RETURN;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        acc_write = 1'b1;
        case (opcode)
          OP_LDI: begin alu_op = ALU_PASS_B; alu_src_b = 1'b1; end
          OP_ADD:       alu_op = ALU_ADD;
          OP_SUB:       alu_op = ALU_SUB;
          OP_AND:       alu_op = ALU_AND;
          OP_NOT:       alu_op = ALU_NOT_A;
          default:      alu_op = ALU_PASS_B;
        endcase
        state_d = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end
      // PC stage resolves the branch from the type bit and the flag snapshot.
      ST_BRANCH: begin
        pc_mux_sel           = PC_SEL_TARGET;
        branch_ctrl[BR_BEQ]  = (opcode == OP_BEQ);
        branch_ctrl[BR_BMI]  = (opcode == OP_BMI);
        branch_ctrl[BR_BNE]  = (opcode == OP_BNE);
        branch_ctrl[BR_BPL]  = (opcode == OP_BPL);
        branch_ctrl[BR_Z]    = flag_z;
        branch_ctrl[BR_N]    = flag_n;
        branch_ctrl[BR_COND] = 1'b1;
        state_d              = ST_FETCH;
      end
      ST_JUMP: begin
        pc_mux_sel       = PC_SEL_TARGET;
        pc_write_signals = PCW_JUMP;
        saved_pc_write   = (opcode == OP_JSR);
        state_d          = ST_FETCH;
      end
      ST_RETURN: begin
        pc_mux_sel       = PC_SEL_SAVED;
        pc_write_signals = PCW_RESTORE;
        state_d          = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    // Strobes drop in the very cycle reset rises, abandoning any instruction.
    if (reset) begin
      ir_write         = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      mem_addr_sel     = 1'b0;
      acc_write        = 1'b0;
      alu_op           = ALU_PASS_B;
      alu_src_b        = 1'b0;
      pc_mux_sel       = PC_SEL_INC;
      branch_ctrl      = '0;
      pc_write_signals = '0;
      saved_pc_write   = 1'b0;
      halted           = 1'b0;
    end
  end

  acc_flag_reg u_flag_reg (
    .clock  (clock),
    .reset  (reset),
    .load   (acc_write),
    .result (acc_result_in),
    .flag_z (flag_z),
    .flag_n (flag_n)
  );

endmodule

// File: doc/acc_control_unit.md
# acc_control_unit

Multicycle control FSM for the accumulator processor, directly upstream of the PC write logic. It sequences fetch, decode, memory and write-back cycles from the instruction register opcode and owns the Z/N flag register. It drives the 7-bit branch control vector, the 4-bit PC write code, the saved-PC write strobe and the PC mux select consumed by the PC stage, plus the memory, IR and accumulator controls.

## Interface
No parameters.
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr_in  in  32  IR output; opcode = instr_in[31:28]
- mem_ready  in  1  memory completes read/write this cycle
- acc_result_in  in  32  value written to accumulator this cycle (flag source)
- ir_write  out  1  load IR from memory data
- mem_read / mem_write  out  1 each  memory strobes
- mem_addr_sel  out  1  0 = PC, 1 = operand address
- acc_write  out  1  accumulator load enable
- alu_op  out  3  000 PASS_B, 001 ADD, 010 SUB, 011 AND, 100 NOT_A
- alu_src_b  out  1  0 = memory data, 1 = immediate
- pc_mux_sel  out  2  00 PC+1, 01 target, 10 savedPC
- branch_ctrl  out  7  {BEQ, BMI, BNE, BPL, Z, N, PCWriteCond}, bit 6 down to bit 0
- pc_write_signals  out  4  {restore, jump, inc, PCWrite}, bit 3 down to bit 0
- saved_pc_write  out  1  savedPC <= current PC
- halted  out  1  FSM in HALT

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 LDA, 3 STA, 4 ADD, 5 SUB, 6 AND, 7 NOT, 8 BEQ, 9 BNE, A BMI, B BPL, C JMP, D JSR, E RTS, F HLT. All 16 legal.
- Moore outputs decoded from state, IR opcode and flags. No combinational path from mem_ready or acc_result_in to any output except ir_write (= mem_ready in FETCH).
- Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, mem_addr_sel=0, ir_write=mem_ready. Stays until mem_ready, then DECODE.
- DECODE: pc_mux_sel=00, pc_write_signals=0011.
  - NOP goes to FETCH; HLT goes to HALT.
  - LDI and NOT go to ALU_WB.
  - LDA, ADD, SUB, AND go to MEM_RD.
  - STA goes to MEM_WR.
  - 8–B go to BRANCH; C–D go to JUMP; E goes to RETURN.
- MEM_RD: mem_read=1, mem_addr_sel=1. Stays until mem_ready, then ALU_WB.
- ALU_WB: acc_write=1. LDI: PASS_B with alu_src_b=1. LDA: PASS_B with alu_src_b=0. ADD/SUB/AND: matching op with alu_src_b=0. NOT: NOT_A. Next state FETCH.
- MEM_WR: mem_write=1, mem_addr_sel=1. Stays until mem_ready, then FETCH.
- BRANCH: pc_mux_sel=01, branch_ctrl={type one-hot, Z, N, 1}. Exactly one type bit set (BEQ=8, BNE=9, BMI=A, BPL=B). The PC stage decides whether to take it. Next state FETCH.
- JUMP: pc_mux_sel=01, pc_write_signals=0101. For JSR only, also saved_pc_write=1; this captures the already-incremented PC. Next state FETCH.
- RETURN: pc_mux_sel=10, pc_write_signals=1001. Next state FETCH.
- HALT: halted=1, all strobes 0. Leaves only on reset.
- Flags: on every edge with acc_write=1, Z <= (acc_result_in == 0) and N <= acc_result_in[31]. Otherwise flags hold. STA, branches and jumps never change flags.

## Timing
- Reset: on the edge with reset=1, state <= FETCH and Z=N=0. While reset=1, all outputs are forced to 0, including halted. The first cycle after reset is FETCH.
- Reset mid-operation abandons the instruction. mem_write and acc_write drop in the same cycle reset rises.
- Cycle counts with mem_ready held at 1:
  - NOP: 2
  - LDI, NOT, STA, branches, JMP, JSR, RTS: 3
  - LDA, ADD, SUB, AND: 4
- Each low mem_ready cycle in FETCH, MEM_RD or MEM_WR adds one cycle; outputs stay constant while stalled.
- The PC stage samples PC controls on the edge ending the state, so PC updates at the end of DECODE, JUMP, RETURN or a taken BRANCH.
- A branch uses the flags as they stand at the start of BRANCH. This includes a write-back from the immediately preceding instruction.

## Structure
- Shared package acc_ctrl_pkg holds:
  - 4-bit opcode constants and state encoding (4-bit: FETCH, DECODE, MEM_RD, ALU_WB, MEM_WR, BRANCH, JUMP, RETURN, HALT)
  - alu_op, pc_mux_sel and pc_write_signals codes
  - branch_ctrl bit positions
- One sub-module, acc_flag_reg: Z/N register with sync reset, loaded on acc_write.

## Test plan
- Reset held 2 cycles, then NOP with mem_ready=1 -> all outputs 0 during reset; FETCH then DECODE with pc_write_signals=0011; back to FETCH on cycle 3.
- LDI with acc_result_in=0 -> ALU_WB with acc_write=1, alu_src_b=1, alu_op=000; Z=1, N=0 afterwards; 3 cycles total.
- ADD with mem_ready low 2 cycles in MEM_RD -> mem_read and mem_addr_sel=1 held 3 cycles; alu_op=001 in ALU_WB; acc_result_in=32'h80000000 gives N=1, Z=0.
- BEQ after Z=1 -> branch_ctrl=7'b1000101 and pc_mux_sel=01; BNE with Z=0, N=0 -> 7'b0010001.
- JSR then RTS -> JUMP: pc_write_signals=0101, saved_pc_write=1; RETURN: pc_mux_sel=10, pc_write_signals=1001, saved_pc_write=0.
- HLT -> halted=1 indefinitely with no strobes; reset asserted in the middle of STA in MEM_WR -> mem_write drops the same cycle, FETCH next.
